// File: rtl/flash_pkg.sv
// Shared types and constants for the flash-to-RAM boot copier.
package flash_pkg;

  localparam int FL_AW   = 22;
  localparam int RAM_AW  = 18;
  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMEOUT_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

endpackage

// File: rtl/flash_boot_loader_wait_timer.sv
// Wait-state timer for the flash handshake; expired when the count reaches TIMEOUT_MAX.
module wait_timer
  import flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TIMEOUT_MAX);

endmodule

// File: rtl/flash_boot_loader.sv
// Copies a block of 16-bit words from flash to RAM at boot, holding the CPU until the copy succeeds.
module flash_boot_loader
  import flash_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FL_AW:1]    flash_base,
  input  logic [RAM_AW-1:0] ram_base,
  input  logic [15:0]       length,
  output logic [FL_AW:1]    fl_addr,
  output logic              fl_read_ctrl,
  input  logic [15:0]       fl_data,
  input  logic              fl_ready,
  output logic              ram_req,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic              ram_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  state_t      state, state_n;
  logic [15:0] remaining;
  logic        timer_clr, timer_en, expired;

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // WAIT_LOW ignores a stale fl_ready=1; only a low level proves the new read started.
  always_comb begin
    state_n   = state;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      IDLE:      if (start) state_n = (length == 16'd0) ? DONE : ISSUE;
      ISSUE: begin
        timer_clr = 1'b1;
        state_n   = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!fl_ready) begin
          timer_clr = 1'b1;
          state_n   = WAIT_HIGH;
        end else if (expired) begin
          state_n = ERROR;
        end else begin
          timer_en = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (fl_ready)     state_n = WRITE;
        else if (expired) state_n = ERROR;
        else              timer_en = 1'b1;
      end
      WRITE:     if (ram_ack) state_n = (remaining == 16'd1) ? DONE : ISSUE;
      DONE:      state_n = IDLE;
      ERROR:     state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ram_req/ram_ack: request held with stable ram_addr/ram_wdata until a one-cycle ack.
  // fl_addr doubles as the flash pointer, so it only moves on the ack in WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_addr      <= '0;
      fl_read_ctrl <= 1'b0;
      ram_req      <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      remaining    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            fl_addr   <= flash_base;
            ram_addr  <= ram_base;
            remaining <= length;
            error     <= 1'b0;
          end
        end
        ISSUE:     fl_read_ctrl <= ~fl_read_ctrl;
        WAIT_HIGH: begin
          if (fl_ready) begin
            ram_wdata <= fl_data;
            ram_req   <= 1'b1;
          end
        end
        WRITE: begin
          if (ram_ack) begin
            ram_req   <= 1'b0;
            fl_addr   <= fl_addr + 1'b1;
            ram_addr  <= ram_addr + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        DONE:      cpu_hold <= 1'b0;
        ERROR: begin
          error   <= 1'b1;
          ram_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader with a 40-cycle flash read model and a delayable RAM model.
module tb_flash_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [22:1] flash_base = '0;
  logic [17:0] ram_base = '0;
  logic [15:0] length = '0;
  logic [22:1] fl_addr;
  logic        fl_read_ctrl;
  logic [15:0] fl_data;
  logic        fl_ready;
  logic        ram_req;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic        busy, done, error, cpu_hold;

  int total = 0;
  int bad   = 0;

  flash_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flash_base   (flash_base),
    .ram_base     (ram_base),
    .length       (length),
    .fl_addr      (fl_addr),
    .fl_read_ctrl (fl_read_ctrl),
    .fl_data      (fl_data),
    .fl_ready     (fl_ready),
    .ram_req      (ram_req),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_ack      (ram_ack),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold)
  );

  // clock
  always #5 clk = ~clk;

  // flash content: word at base 0x100 is 0xA000, incrementing per address
  function automatic logic [15:0] flash_word(input logic [21:0] a);
    logic [21:0] d;
    d = a - 22'h000100;
    return 16'hA000 + d[15:0];
  endfunction

  // flash read controller model
  bit          stuck = 1'b0;
  logic        prev_ctrl;
  int          fl_cnt;
  int          toggles = 0;
  logic [21:0] rd_addr;
  logic [21:0] fl_addr_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_ctrl <= 1'b0;
      fl_ready  <= 1'b1;
      fl_cnt    <= 0;
      fl_data   <= '0;
    end else if (fl_read_ctrl != prev_ctrl) begin
      prev_ctrl <= fl_read_ctrl;
      toggles   <= toggles + 1;
      rd_addr   <= fl_addr;
      fl_addr_q.push_back(fl_addr);
      if (!stuck) begin
        fl_ready <= 1'b0;
        fl_cnt   <= 40;
      end
    end else if (fl_cnt > 0) begin
      fl_cnt <= fl_cnt - 1;
      if (fl_cnt == 1) begin
        fl_ready <= 1'b1;
        fl_data  <= flash_word(rd_addr);
      end
    end
  end

  // RAM model with programmable ack delay and a hold-stability monitor
  int          ram_delay = 0;
  int          wcnt;
  int          req_cycles = 0;
  int          stab_err = 0;
  int          done_cnt = 0;
  logic        req_prev;
  logic [17:0] cap_addr;
  logic [15:0] cap_data;
  logic [33:0] wr_q[$];
  logic [33:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_ack  <= 1'b0;
      wcnt     <= 0;
      req_prev <= 1'b0;
    end else begin
      req_prev <= ram_req;
      if (ram_req) begin
        req_cycles <= req_cycles + 1;
        if (!req_prev) begin
          cap_addr <= ram_addr;
          cap_data <= ram_wdata;
        end else if (ram_addr != cap_addr || ram_wdata != cap_data) begin
          stab_err <= stab_err + 1;
        end
      end
      if (ram_req && !ram_ack) begin
        if (wcnt >= ram_delay) begin
          ram_ack <= 1'b1;
          wcnt    <= 0;
          wr_q.push_back({ram_addr, ram_wdata});
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        ram_ack <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // driver and checker tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_copy(input logic [21:0] fb, input logic [17:0] rb, input logic [15:0] len);
    @(negedge clk);
    flash_base = fb;
    ram_base   = rb;
    length     = len;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!done && !error && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_within_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_sb(input int wbase);
    int i;
    int idx;
    logic [33:0] e;
    check("write_count", 64'(wr_q.size() - wbase), 64'(exp_q.size()));
    i = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = wbase + i;
      check("ram_write", (idx < wr_q.size()) ? 64'(wr_q[idx]) : 64'hDEAD_BEEF_DEAD, 64'(e));
      i++;
    end
  endtask

  int tb_base, db_base, wb_base, rq_base, se_base, fa_base, n;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_ram_req", 64'(ram_req), 64'd0);
    check("rst_read_ctrl", 64'(fl_read_ctrl), 64'd0);
    check("rst_fl_addr", 64'(fl_addr), 64'd0);
    rst = 1'b1;

    // four-word copy
    tb_base = toggles; db_base = done_cnt; wb_base = wr_q.size();
    start_copy(22'h000100, 18'h00000, 16'd4);
    check("c4_busy", 64'(busy), 64'd1);
    check("c4_hold_during", 64'(cpu_hold), 64'd1);
    wait_end(2000);
    check("c4_done", 64'(done), 64'd1);
    check("c4_error", 64'(error), 64'd0);
    check("c4_cpu_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    check("c4_done_pulse", 64'(done), 64'd0);
    check("c4_idle", 64'(busy), 64'd0);
    check("c4_toggles", 64'(toggles - tb_base), 64'd4);
    check("c4_done_count", 64'(done_cnt - db_base), 64'd1);
    exp_q.push_back({18'h00000, 16'hA000});
    exp_q.push_back({18'h00001, 16'hA001});
    exp_q.push_back({18'h00002, 16'hA002});
    exp_q.push_back({18'h00003, 16'hA003});
    check_sb(wb_base);

    // zero length
    tb_base = toggles; rq_base = req_cycles;
    start_copy(22'h000100, 18'h00000, 16'd0);
    check("z_done_early", 64'(done), 64'd0);
    check("z_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("z_done", 64'(done), 64'd1);
    check("z_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("z_done_pulse", 64'(done), 64'd0);
    check("z_toggles", 64'(toggles - tb_base), 64'd0);
    check("z_ram_req", 64'(req_cycles - rq_base), 64'd0);

    // flash never drops fl_ready: timeout
    do_reset();
    stuck = 1'b1;
    tb_base = toggles; db_base = done_cnt;
    start_copy(22'h000100, 18'h00000, 16'd2);
    repeat (250) @(negedge clk);
    check("to_no_error_yet", 64'(error), 64'd0);
    check("to_busy", 64'(busy), 64'd1);
    n = 0;
    while (!error && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("to_error", 64'(error), 64'd1);
    check("to_cpu_hold", 64'(cpu_hold), 64'd1);
    check("to_ram_req", 64'(ram_req), 64'd0);
    check("to_idle", 64'(busy), 64'd0);
    check("to_toggles", 64'(toggles - tb_base), 64'd1);
    check("to_no_done", 64'(done_cnt - db_base), 64'd0);

    // retry with a working flash; fl_ready is still the stale high level
    stuck = 1'b0;
    wb_base = wr_q.size();
    start_copy(22'h000100, 18'h00020, 16'd2);
    check("rt_error_cleared", 64'(error), 64'd0);
    wait_end(1000);
    check("rt_done", 64'(done), 64'd1);
    check("rt_cpu_hold", 64'(cpu_hold), 64'd0);
    exp_q.push_back({18'h00020, 16'hA000});
    exp_q.push_back({18'h00021, 16'hA001});
    check_sb(wb_base);

    // slow RAM ack
    ram_delay = 10;
    wb_base = wr_q.size(); rq_base = req_cycles; se_base = stab_err;
    start_copy(22'h000140, 18'h01000, 16'd3);
    wait_end(2000);
    check("sr_done", 64'(done), 64'd1);
    check("sr_stable", 64'(stab_err - se_base), 64'd0);
    check("sr_req_cycles", 64'(req_cycles - rq_base), 64'd36);
    exp_q.push_back({18'h01000, 16'hA040});
    exp_q.push_back({18'h01001, 16'hA041});
    exp_q.push_back({18'h01002, 16'hA042});
    check_sb(wb_base);
    ram_delay = 0;

    // address wrap on both sides
    wb_base = wr_q.size(); fa_base = fl_addr_q.size();
    start_copy(22'h3FFFFF, 18'h3FFFF, 16'd2);
    wait_end(1000);
    check("wr_done", 64'(done), 64'd1);
    check("wr_fl_addr0", (fl_addr_q.size() > fa_base) ? 64'(fl_addr_q[fa_base]) : 64'hBAD, 64'h3FFFFF);
    check("wr_fl_addr1", (fl_addr_q.size() > fa_base + 1) ? 64'(fl_addr_q[fa_base + 1]) : 64'hBAD, 64'h000000);
    exp_q.push_back({18'h3FFFF, 16'h9EFF});
    exp_q.push_back({18'h00000, 16'h9F00});
    check_sb(wb_base);

    // reset during WAIT_HIGH of word 2
    do_reset();
    tb_base = toggles; wb_base = wr_q.size();
    start_copy(22'h000200, 18'h00100, 16'd4);
    n = 0;
    while ((toggles - tb_base) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mr_second_read", 64'(toggles - tb_base), 64'd2);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_read_ctrl", 64'(fl_read_ctrl), 64'd0);
    check("mr_fl_addr", 64'(fl_addr), 64'd0);
    check("mr_ram_req", 64'(ram_req), 64'd0);
    check("mr_ram_addr", 64'(ram_addr), 64'd0);
    check("mr_ram_wdata", 64'(ram_wdata), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_error", 64'(error), 64'd0);
    check("mr_cpu_hold", 64'(cpu_hold), 64'd1);
    check("mr_one_write", 64'(wr_q.size() - wb_base), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wb_base = wr_q.size();
    start_copy(22'h000200, 18'h00100, 16'd4);
    wait_end(2000);
    check("mr_restart_done", 64'(done), 64'd1);
    check("mr_restart_hold", 64'(cpu_hold), 64'd0);
    exp_q.push_back({18'h00100, 16'hA100});
    exp_q.push_back({18'h00101, 16'hA101});
    exp_q.push_back({18'h00102, 16'hA102});
    exp_q.push_back({18'h00103, 16'hA103});
    check_sb(wb_base);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 The block SHALL use clock clk (all state updates on its rising edge) and reset rst, asynchronous, active-low.
REQ-002 The block SHALL have the following ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse that begins a copy.
- flash_base, in, 22 [22:1]: first flash word address.
- ram_base, in, 18: first RAM word address.
- length, in, 16: number of 16-bit words to copy.
- fl_addr, out, 22 [22:1]: word address to the flash read controller.
- fl_read_ctrl, out, 1: toggle-style read request; each edge requests one read.
- fl_data, in, 16: read data from the flash read controller.
- fl_ready, in, 1: flash read controller ready; goes low while a read runs, high when data is valid.
- ram_req, out, 1: RAM write request, held until acknowledged.
- ram_addr, out, 18: RAM write address.
- ram_wdata, out, 16: RAM write data.
- ram_ack, in, 1: one-cycle RAM write acknowledge.
- busy, out, 1: copy in progress.
- done, out, 1: one-cycle pulse when a copy completes successfully.
- error, out, 1: sticky timeout flag.
- cpu_hold, out, 1: holds the CPU in reset until the copy is done.

Function
REQ-003 The state machine SHALL have the states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, WRITE, DONE and ERROR.
REQ-004 In IDLE, start=1 SHALL latch flash_base, ram_base and length into the working counters, clear error, and move to ISSUE on the next cycle.
REQ-005 In IDLE, start=1 with length=0 SHALL move directly to DONE, with no flash or RAM traffic.
REQ-006 Outside IDLE, start SHALL be ignored.
REQ-007 ISSUE SHALL, for one cycle:
- drive fl_addr with the current flash address;
- invert fl_read_ctrl;
- clear the wait timer;
- move to WAIT_LOW.
REQ-008 fl_addr SHALL stay stable from ISSUE until WAIT_HIGH exits, because the flash controller re-samples the address mid-read.
REQ-009 WAIT_LOW SHALL move to WAIT_HIGH when it samples fl_ready=0; a stale fl_ready=1 left from the previous read SHALL NOT be taken as completion.
REQ-010 WAIT_HIGH, on sampling fl_ready=1, SHALL register fl_data into ram_wdata, assert ram_req and move to WRITE.
REQ-011 Wait timer: 8-bit, cleared on entry to WAIT_LOW and to WAIT_HIGH, incremented each cycle in those states; reaching 255 SHALL move to ERROR.
REQ-012 In WRITE, ram_req, ram_addr and ram_wdata SHALL stay constant until ram_ack=1. On the ack cycle the block SHALL:
- deassert ram_req;
- increment the flash and RAM addresses;
- decrement the remaining count;
- move to DONE if the remaining count was 1, otherwise to ISSUE.
REQ-013 Flash address arithmetic SHALL wrap modulo 2^22 and RAM address arithmetic modulo 2^18, with no error raised.
REQ-014 DONE SHALL assert done for exactly one cycle, release cpu_hold (it stays 0 until reset), and return to IDLE.
REQ-015 ERROR SHALL:
- set error=1 (sticky);
- deassert ram_req;
- leave cpu_hold=1;
- return to IDLE, where a new start retries the copy.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Per-word latency SHALL be 1 (ISSUE) + the WAIT_LOW cycles + the WAIT_HIGH cycles + the WRITE cycles up to and including the ack.

Reset
REQ-018 rst=0 SHALL immediately force:
- state to IDLE;
- fl_read_ctrl=0, fl_addr=0;
- ram_req=0, ram_addr=0, ram_wdata=0;
- busy=0, done=0, error=0;
- cpu_hold=1;
- all counters and the wait timer to 0.
REQ-019 Reset mid-copy SHALL abandon the copy without completing the pending RAM write.

Structure
REQ-020 The state encodings and the TIMEOUT_MAX constant (255) SHALL live in the shared package flash_pkg, together with the flash word-address width (22) and the RAM address width (18).
REQ-021 The wait timer SHALL be a sub-module named wait_timer (8-bit, with clear, enable and expired ports); everything else SHALL be a single FSM plus its datapath registers.

Verification
REQ-022 The bench SHALL cover these directed scenarios, paired with a flash controller model whose read takes 40 cycles and a RAM model:
- Copy of 4 words (flash_base=0x000100, ram_base=0x00000, length=4, flash words 0xA000..0xA003): RAM 0..3 holds 0xA000..0xA003; exactly 4 read_ctrl toggles; one done pulse; cpu_hold falls.
- length=0: done pulses 2 cycles after start; no toggles; no ram_req.
- Flash model holds fl_ready=1 and never drops it: error=1 after 255 WAIT_LOW cycles; cpu_hold stays 1; a following start retries with error cleared.
- RAM ack delayed 10 cycles per word: ram_req, ram_addr and ram_wdata stay stable throughout; data still correct.
- ram_base=0x3FFFF, length=2: writes go to 0x3FFFF then 0x00000; flash_base=0x3FFFFF wraps to 0x000000.
- rst asserted during WAIT_HIGH of word 2: all outputs take reset values immediately; a restart after reset copies all words correctly.
